// File: rtl/alu_seq_n.sv
// alu_seq_n: registered EX-stage ALU. Logic/add/compare ops complete in one
// clock; MULT/MULTU/DIV/DIVU run iteratively (shift-add / restoring divide)
// behind a start/busy/done handshake and produce HI/LO.
module alu_seq_n #(
  parameter int WORD_SIZE           = 32,
  parameter int CONTROL_SIGNAL_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CONTROL_SIGNAL_SIZE-1:0] control,
  input  logic [WORD_SIZE-1:0]           input_a,
  input  logic [WORD_SIZE-1:0]           input_b,
  output logic                           busy,
  output logic                           done,
  output logic [WORD_SIZE-1:0]           result,
  output logic [WORD_SIZE-1:0]           result_hi,
  output logic                           zero,
  output logic                           cout,
  output logic                           err_overflow,
  output logic                           err_div_zero,
  output logic                           err_invalid_control
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(WORD_SIZE);
  localparam int CS = CONTROL_SIGNAL_SIZE;

  localparam logic [CS-1:0] OP_AND   = CS'(4'h0);
  localparam logic [CS-1:0] OP_OR    = CS'(4'h1);
  localparam logic [CS-1:0] OP_ADD   = CS'(4'h2);
  localparam logic [CS-1:0] OP_ADDU  = CS'(4'h3);
  localparam logic [CS-1:0] OP_SLTU  = CS'(4'h5);
  localparam logic [CS-1:0] OP_SUB   = CS'(4'h6);
  localparam logic [CS-1:0] OP_SLT   = CS'(4'h7);
  localparam logic [CS-1:0] OP_MULT  = CS'(4'h8);
  localparam logic [CS-1:0] OP_MULTU = CS'(4'h9);
  localparam logic [CS-1:0] OP_DIV   = CS'(4'hA);
  localparam logic [CS-1:0] OP_DIVU  = CS'(4'hB);
  localparam logic [CS-1:0] OP_NOR   = CS'(4'hC);

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [W-1:0]    acc_hi;     // mul: running product high / div: partial remainder
  logic [W-1:0]    acc_lo;     // mul: multiplier -> product low / div: dividend -> quotient
  logic [W-1:0]    opnd_b;     // multiplicand or divisor magnitude
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            div_zero_q;
  logic            div_ovf_q;

  // Single-cycle datapath and op decode
  logic [W:0]      sum_ext;
  logic [W:0]      diff_ext;
  logic [W-1:0]    sc_result;
  logic            sc_cout;
  logic            sc_ovf;
  logic            sc_invalid;
  logic            op_muldiv;
  logic            op_div;
  logic            op_signed;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;

  assign sum_ext  = {1'b0, input_a} + {1'b0, input_b};
  assign diff_ext = {1'b0, input_a} - {1'b0, input_b};

  // Decode control into the single-cycle result/flags and the mul/div mode bits
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    sc_result  = '0;
    sc_cout    = 1'b0;
    sc_ovf     = 1'b0;
    sc_invalid = 1'b0;
    op_muldiv  = 1'b0;
    op_div     = 1'b0;
    op_signed  = 1'b0;
    case (control)
      OP_AND:   sc_result = input_a & input_b;
      OP_OR:    sc_result = input_a | input_b;
      OP_NOR:   sc_result = ~(input_a | input_b);
      OP_ADD: begin
        sc_result = sum_ext[W-1:0];
        sc_cout   = sum_ext[W];
        sc_ovf    = (input_a[W-1] == input_b[W-1]) && (sum_ext[W-1] != input_a[W-1]);
      end
      OP_ADDU: begin
        sc_result = sum_ext[W-1:0];
        sc_cout   = sum_ext[W];
        sc_ovf    = sum_ext[W];
      end
      OP_SUB: begin
        sc_result = diff_ext[W-1:0];
        sc_cout   = diff_ext[W];
        sc_ovf    = (input_a[W-1] != input_b[W-1]) && (diff_ext[W-1] != input_a[W-1]);
      end
      OP_SLT:   sc_result = {{(W-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
      OP_SLTU:  sc_result = {{(W-1){1'b0}}, (input_a < input_b)};
      OP_MULT:  begin op_muldiv = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_muldiv = 1'b1; end
      OP_DIV:   begin op_muldiv = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
      OP_DIVU:  begin op_muldiv = 1'b1; op_div = 1'b1; end
      default:  sc_invalid = 1'b1;
    endcase
  end

  // Operand magnitudes for signed mul/div; MIN maps to itself, which is its correct unsigned magnitude
  assign mag_a = (op_signed && input_a[W-1]) ? -input_a : input_a;
  assign mag_b = (op_signed && input_b[W-1]) ? -input_b : input_b;

  // One iteration step: shift-add multiply or restoring shift-subtract divide
  logic [W:0]      mul_sum;
  logic [W:0]      div_sh;
  logic            div_ge;
  logic [W-1:0]    div_sub;
  logic [W-1:0]    step_hi;
  logic [W-1:0]    step_lo;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  assign div_sh  = {acc_hi, acc_lo[W-1]};
  assign div_ge  = (div_sh >= {1'b0, opnd_b});
  // When div_ge holds the true difference is below the divisor, so W bits suffice.
  assign div_sub = div_sh[W-1:0] - opnd_b;

  always_comb begin
    if (is_div) begin
      step_hi = div_ge ? div_sub : div_sh[W-1:0];
      step_lo = {acc_lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  // Final step plus sign correction, written to the outputs in FIX
  logic [2*W-1:0]  prod;
  logic [W-1:0]    fin_hi;
  logic [W-1:0]    fin_lo;

  assign prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

  always_comb begin
    if (div_zero_q) begin
      // acc_hi holds |A|; the remainder sign fix restores the raw dividend.
      fin_lo = '1;
      fin_hi = neg_r ? -acc_hi : acc_hi;
    end else if (is_div) begin
      fin_lo = neg_q ? -step_lo : step_lo;
      fin_hi = neg_r ? -step_hi : step_hi;
    end else begin
      fin_lo = prod[W-1:0];
      fin_hi = prod[2*W-1:W];
    end
  end

  assign zero = (result == '0);

  // Control FSM, iteration state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (!rst_n) begin
      state               <= IDLE;
      count               <= '0;
      acc_hi              <= '0;
      acc_lo              <= '0;
      opnd_b              <= '0;
      is_div              <= 1'b0;
      neg_q               <= 1'b0;
      neg_r               <= 1'b0;
      div_zero_q          <= 1'b0;
      div_ovf_q           <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      result              <= '0;
      result_hi           <= '0;
      cout                <= 1'b0;
      err_overflow        <= 1'b0;
      err_div_zero        <= 1'b0;
      err_invalid_control <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_muldiv) begin
              state      <= RUN;
              busy       <= 1'b1;
              count      <= CW'(W - 1);
              is_div     <= op_div;
              neg_q      <= op_signed && (input_a[W-1] ^ input_b[W-1]);
              neg_r      <= op_signed && op_div && input_a[W-1];
              div_zero_q <= op_div && (input_b == '0);
              div_ovf_q  <= op_signed && op_div && (input_a == MIN_VAL) && (input_b == '1);
              opnd_b     <= mag_b;
              if (op_div && (input_b == '0)) begin
                acc_hi <= mag_a;
                acc_lo <= '0;
              end else begin
                acc_hi <= '0;
                acc_lo <= mag_a;
              end
            end else begin
              result              <= sc_result;
              result_hi           <= '0;
              cout                <= sc_cout;
              err_overflow        <= sc_ovf;
              err_div_zero        <= 1'b0;
              err_invalid_control <= sc_invalid;
              done                <= 1'b1;
            end
          end
        end
        RUN: begin
          // W-1 steps here; the last step is folded into FIX to hold latency at W+1.
          if (!div_zero_q) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
          end
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          result              <= fin_lo;
          result_hi           <= fin_hi;
          cout                <= 1'b0;
          err_overflow        <= div_ovf_q;
          err_div_zero        <= div_zero_q;
          err_invalid_control <= 1'b0;
          done                <= 1'b1;
          busy                <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed self-checking bench for alu_seq_n (WORD_SIZE=32).
module tb_alu_seq_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  control;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        cout;
  logic        err_overflow;
  logic        err_div_zero;
  logic        err_invalid_control;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  alu_seq_n #(.WORD_SIZE(32), .CONTROL_SIGNAL_SIZE(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .control             (control),
    .input_a             (input_a),
    .input_b             (input_b),
    .busy                (busy),
    .done                (done),
    .result              (result),
    .result_hi           (result_hi),
    .zero                (zero),
    .cout                (cout),
    .err_overflow        (err_overflow),
    .err_div_zero        (err_div_zero),
    .err_invalid_control (err_invalid_control)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one start at a negedge; returns at the following negedge (cycle 1 after acceptance).
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    control = c;
    input_a = a;
    input_b = b;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Waits for done from cycle lat_in; reports cycle of done and whether busy stayed high before it.
  task automatic wait_done(input int lat_in, output int lat, output bit busy_ok);
    lat     = lat_in;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_flags(input string tag, input logic c, input logic ov,
                             input logic dz, input logic inv);
    check({tag, ".cout"}, 32'(cout), 32'(c));
    check({tag, ".ovf"},  32'(err_overflow), 32'(ov));
    check({tag, ".dz"},   32'(err_div_zero), 32'(dz));
    check({tag, ".inv"},  32'(err_invalid_control), 32'(inv));
  endtask

  initial begin
    int  lat;
    bit  bok;
    int  cnt0;

    rst_n   = 1'b0;
    start   = 1'b0;
    control = 4'h0;
    input_a = '0;
    input_b = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.result", result, 32'h0);
    check("rst.hi", result_hi, 32'h0);
    check("rst.zero", 32'(zero), 32'h1);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD signed overflow, one-cycle latency
    issue(4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add.done", 32'(done), 32'h1);
    check("add.result", result, 32'h8000_0000);
    check("add.hi", result_hi, 32'h0);
    check("add.zero", 32'(zero), 32'h0);
    check_flags("add", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("add.hold_done", 32'(done), 32'h0);
    check("add.hold_result", result, 32'h8000_0000);

    // ADDU carry out, zero result
    issue(4'h3, 32'hFFFF_FFFF, 32'h0000_0001);
    check("addu.result", result, 32'h0);
    check("addu.zero", 32'(zero), 32'h1);
    check_flags("addu", 1'b1, 1'b1, 1'b0, 1'b0);

    // SUB with borrow, no overflow
    issue(4'h6, 32'h0000_0005, 32'h0000_0007);
    check("sub.result", result, 32'hFFFF_FFFE);
    check_flags("sub", 1'b1, 1'b0, 1'b0, 1'b0);

    // SUB signed overflow MIN-1
    issue(4'h6, 32'h8000_0000, 32'h0000_0001);
    check("subov.result", result, 32'h7FFF_FFFF);
    check_flags("subov", 1'b0, 1'b1, 1'b0, 1'b0);

    // SLT signed vs SLTU unsigned on the same operands
    issue(4'h7, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt.result", result, 32'h0000_0001);
    issue(4'h5, 32'hFFFF_FFFF, 32'h0000_0001);
    check("sltu.result", result, 32'h0);
    check("sltu.zero", 32'(zero), 32'h1);

    // NOR
    issue(4'hC, 32'h0000_0000, 32'h0000_0000);
    check("nor.result", result, 32'hFFFF_FFFF);

    // Back-to-back AND then OR on consecutive cycles
    @(negedge clk);
    start = 1'b1; control = 4'h0; input_a = 32'hF0F0_F0F0; input_b = 32'hFF00_FF00;
    @(negedge clk);
    check("b2b.and_done", 32'(done), 32'h1);
    check("b2b.and", result, 32'hF000_F000);
    control = 4'h1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.or_done", 32'(done), 32'h1);
    check("b2b.or", result, 32'hFFF0_FFF0);

    // MULT -3 x 5
    issue(4'h8, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(1, lat, bok);
    check("mult.latency", 32'(lat), 32'd33);
    check("mult.busy_run", 32'(bok), 32'h1);
    check("mult.busy_done", 32'(busy), 32'h0);
    check("mult.hi", result_hi, 32'hFFFF_FFFF);
    check("mult.lo", result, 32'hFFFF_FFF1);
    check_flags("mult", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle op after mul clears HI
    issue(4'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    check("and.after_mul_hi", result_hi, 32'h0);
    check("and.after_mul", result, 32'h1234_5678);

    // DIVU 100 / 7
    issue(4'hB, 32'h0000_0064, 32'h0000_0007);
    wait_done(1, lat, bok);
    check("divu.latency", 32'(lat), 32'd33);
    check("divu.q", result, 32'h0000_000E);
    check("divu.r", result_hi, 32'h0000_0002);

    // DIV -100 / 7
    issue(4'hA, 32'hFFFF_FF9C, 32'h0000_0007);
    wait_done(1, lat, bok);
    check("div.q", result, 32'hFFFF_FFF2);
    check("div.r", result_hi, 32'hFFFF_FFFE);
    check_flags("div", 1'b0, 1'b0, 1'b0, 1'b0);

    // DIV by zero
    issue(4'hA, 32'h0000_0005, 32'h0000_0000);
    wait_done(1, lat, bok);
    check("div0.latency", 32'(lat), 32'd33);
    check("div0.q", result, 32'hFFFF_FFFF);
    check("div0.r", result_hi, 32'h0000_0005);
    check_flags("div0", 1'b0, 1'b0, 1'b1, 1'b0);

    // DIV MIN / -1
    issue(4'hA, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, lat, bok);
    check("divov.q", result, 32'h8000_0000);
    check("divov.r", result_hi, 32'h0);
    check_flags("divov", 1'b0, 1'b1, 1'b0, 1'b0);

    // MULTU with a SUB start at cycle 5 that must be ignored
    repeat (2) @(negedge clk);
    cnt0 = done_cnt;
    issue(4'h9, 32'h0001_0000, 32'h0001_0001);
    repeat (3) @(negedge clk);
    start = 1'b1; control = 4'h6; input_a = 32'h0000_0009; input_b = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, bok);
    check("ign.latency", 32'(lat), 32'd33);
    check("ign.busy_run", 32'(bok), 32'h1);
    check("ign.hi", result_hi, 32'h0000_0001);
    check("ign.lo", result, 32'h0001_0000);
    repeat (5) @(negedge clk);
    check("ign.done_count", 32'(done_cnt - cnt0), 32'd1);
    check("ign.hold_lo", result, 32'h0001_0000);

    // MULTU aborted by reset at cycle 10
    cnt0 = done_cnt;
    issue(4'h9, 32'h0000_0003, 32'h0000_0004);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.result", result, 32'h0);
    check("abort.hi", result_hi, 32'h0);
    check("abort.zero", 32'(zero), 32'h1);
    check("abort.busy", 32'(busy), 32'h0);
    check("abort.done", 32'(done), 32'h0);
    check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort.no_done", 32'(done_cnt - cnt0), 32'd0);

    // Invalid control code
    issue(4'hF, 32'h1234_5678, 32'h0000_0001);
    check("inv.done", 32'(done), 32'h1);
    check("inv.result", result, 32'h0);
    check("inv.hi", result_hi, 32'h0);
    check_flags("inv", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
